spi_register_file: RTL and testbench
====================================

# spi_register_file

Register and stream endpoint on the SPI subperipheral bus, directly downstream of `spi_peripheral`. It decodes the latched address byte and services single- or multi-byte reads and writes:
- chip ID
- scratch register
- control register driving fabric outputs
- optional byte-stream FIFO that fabric logic fills and the SPI host drains

It returns read data on the subperipheral input lines of `spi_peripheral` before the first data bit is shifted out.

## Interface
Parameters:
- `CHIP_ID`, 8'h81, value returned at address 0xDB.
- `FIFO_DEPTH`, 16, stream FIFO entries; power of two, 2..64.

Ports:
- `system_clock`  in  1  system clock; all logic on rising edge.
- `system_reset`  in  1  synchronous, active-high reset.
- `subperipheral_address_in`  in  8  address byte from the SPI peripheral.
- `subperipheral_address_in_valid`  in  1  high from address latch until chip-select release.
- `subperipheral_data_in`  in  8  write byte from the SPI peripheral.
- `subperipheral_data_in_valid`  in  1  rises once per completed data byte.
- `subperipheral_data_out`  out  8  read byte to the SPI peripheral.
- `subperipheral_data_out_valid`  out  1  read byte valid; 0 for unmapped addresses.
- `control_out`  out  8  contents of the control register.
- `fifo_data_in`  in  8  stream byte from fabric.
- `fifo_data_in_valid`  in  1  push strobe, one byte per high cycle.
- `fifo_full_out`  out  1  FIFO holds `FIFO_DEPTH` entries.

## Operation
- **Transaction start:** a rising edge of `address_in_valid` latches the address.
- **Byte strobe:** each rising edge of `data_in_valid` is one byte strobe. A level held high never re-triggers.
- **Address map:**
  - 0xDB: read-only, returns `CHIP_ID`.
  - 0x10: scratch, R/W.
  - 0x11: control, R/W, drives `control_out`.
  - 0x20: stream read; each byte strobe pops one entry.
  - 0x21: FIFO status, read-only. Bit 7 is the sticky overflow flag; bits 6:0 are the entry count.
- **Writes:** every byte strobe to 0x10/0x11 writes `data_in`. In multi-byte writes the last byte wins. Strobes to read-only or unmapped addresses are ignored.
- **Reads:**
  - 0xDB/0x10/0x11/0x21 return the same value for every byte of a burst; the value is resampled after each strobe.
  - 0x20 returns the FIFO head. On each strobe the head is popped and the next head is presented.
- **Empty FIFO read (0x20):** returns 0x00 with valid=1; no pop, count stays 0.
- **Overflow:** a push when full is dropped and sets overflow. Overflow clears on a byte strobe at 0x21.
- **Full/empty evaluation:** evaluated on the registered count before the same-cycle pop. A push while full is dropped even if a pop happens in that cycle.
- **Simultaneous push and pop** (not full, not empty): both take effect and the count is unchanged.
- **Pointers:** read/write pointers are `$clog2(FIFO_DEPTH)` bits and wrap naturally. Count is `$clog2(FIFO_DEPTH)+1` bits, zero-extended into status bits 6:0.
- **Transaction end:** falling edge of `address_in_valid` returns to idle. `data_out` is 0 and `data_out_valid` is 0 in idle.
- **States:**
  - IDLE → ADDRESSED on the `address_in_valid` rise.
  - ADDRESSED → IDLE on the `address_in_valid` fall.
  - No other states; FIFO pushes proceed in either state.
- **Reset:** reset mid-transaction returns to IDLE. It clears scratch, control, FIFO pointers, count and overflow.
- **Reset values:** `data_out`=0, `data_out_valid`=0, `control_out`=0, `fifo_full_out`=0.

## Timing
- Address rise sampled at cycle N → `data_out`/`data_out_valid` registered at N+1.
- Byte strobe detected at cycle M:
  - write lands in its register at M+1, and `control_out` updates at M+1;
  - FIFO pop takes effect at M+1, and the new head appears on `data_out` at M+1.
- Push sampled at cycle P is visible in count and on `data_out` (when it fills an empty FIFO during a 0x20 read) at P+1.
- Address fall sampled at F → `data_out_valid`=0 at F+1.
- Total response latency is 1 cycle after the edge detect, which is itself registered.
- Host SPI clock high/low phases must each exceed 6 system clocks. This covers the synchronizer, edge detect and response, so the next bit 7 is correct when shifted.

## Configuration
- Macro: `SPI_REGISTER_FILE_FIFO_EN`.
- Defined:
  - FIFO, addresses 0x20/0x21, `fifo_full_out` and overflow logic are built.
- Undefined:
  - 0x20/0x21 behave as unmapped (`data_out_valid`=0, strobes ignored);
  - `fifo_data_in*` are ignored;
  - `fifo_full_out` is tied 0;
  - `FIFO_DEPTH` is unused.

## Test plan
- Reset, then assert address 0xDB → `data_out`=0x81 and valid=1 one cycle after the address-valid edge. Release → valid=0 at F+1.
- Write address 0x11 with bytes 0x5A then 0xC3 → `control_out`=0x5A after strobe 1, 0xC3 after strobe 2. A subsequent 0x11 read returns 0xC3.
- Push 0x01..0x10 with `FIFO_DEPTH`=16, then push 0xFF:
  - `fifo_full_out`=1 and 0xFF is dropped;
  - status read returns 0x90;
  - a second status read returns 0x10.
- Burst-read 0x20 for 17 bytes after the previous fill → 0x01..0x10, then 0x00 on byte 17. Count is 0 and no pointer corruption occurs after wrap.
- Push and pop in the same cycle with count 5 → count stays 5. Reset asserted mid-burst → `data_out_valid`=0, `control_out`=0, count=0 next cycle.
- Access unmapped 0x42 (and 0x20 with the macro undefined) → `data_out_valid` stays 0 and writes change nothing.

Source files
------------

// File: rtl/spi_register_file.sv
// SPI register/stream endpoint: chip ID, scratch, control, optional stream FIFO (SPI_REGISTER_FILE_FIFO_EN).
// Latency: read data registered 1 cycle after the address rise or a byte strobe is detected.
// Backpressure: none; pushes into a full FIFO are dropped and set a sticky overflow flag.
module spi_register_file #(
    parameter logic [7:0] CHIP_ID    = 8'h81,
    parameter int         FIFO_DEPTH = 16
) (
    input  logic       system_clock,
    input  logic       system_reset,
    input  logic [7:0] subperipheral_address_in,
    input  logic       subperipheral_address_in_valid,
    input  logic [7:0] subperipheral_data_in,
    input  logic       subperipheral_data_in_valid,
    output logic [7:0] subperipheral_data_out,
    output logic       subperipheral_data_out_valid,
    output logic [7:0] control_out,
    input  logic [7:0] fifo_data_in,
    input  logic       fifo_data_in_valid,
    output logic       fifo_full_out
);
    localparam logic [7:0] ADDR_CHIP_ID = 8'hDB;
    localparam logic [7:0] ADDR_SCRATCH = 8'h10;
    localparam logic [7:0] ADDR_CONTROL = 8'h11;
    localparam logic [7:0] ADDR_STREAM  = 8'h20;
    localparam logic [7:0] ADDR_STATUS  = 8'h21;

    typedef enum logic {ST_IDLE, ST_ADDRESSED} state_t;

    state_t     r_state;
    logic       r_addr_vld_d;
    logic       r_data_vld_d;
    logic [7:0] r_addr;
    logic [7:0] r_scratch;
    logic [7:0] r_control;
    logic [7:0] r_data_out;
    logic       r_data_out_vld;

    logic       w_addr_rise;
    logic       w_strobe;
    logic [7:0] w_cur_addr;
    logic [7:0] w_scratch_nxt;
    logic [7:0] w_control_nxt;
    logic [7:0] w_rd_dat;
    logic       w_rd_vld;

    assign w_addr_rise   = subperipheral_address_in_valid & ~r_addr_vld_d;
    assign w_strobe      = (r_state == ST_ADDRESSED) & subperipheral_address_in_valid
                         & subperipheral_data_in_valid & ~r_data_vld_d;
    assign w_cur_addr    = (r_state == ST_IDLE) ? subperipheral_address_in : r_addr;
    assign w_scratch_nxt = (w_strobe && r_addr == ADDR_SCRATCH) ? subperipheral_data_in : r_scratch;
    assign w_control_nxt = (w_strobe && r_addr == ADDR_CONTROL) ? subperipheral_data_in : r_control;

`ifdef SPI_REGISTER_FILE_FIFO_EN
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] LP_FULL = CW'(FIFO_DEPTH);

    logic [7:0]    r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_rd_ptr;
    logic [AW-1:0] r_wr_ptr;
    logic [CW-1:0] r_count;
    logic          r_ovf;

    logic          w_full;
    logic          w_empty;
    logic          w_push;
    logic          w_pop;
    logic          w_ovf_nxt;
    logic [AW-1:0] w_rd_ptr_nxt;
    logic [CW-1:0] w_count_nxt;
    logic [CW-1:0] w_left;
    logic [7:0]    w_head_nxt;
    logic [7:0]    w_status_nxt;

    // Full/empty come from the registered count, so a pop cannot make room for a same-cycle push.
    assign w_full       = (r_count == LP_FULL);
    assign w_empty      = (r_count == '0);
    assign w_push       = fifo_data_in_valid & ~w_full;
    assign w_pop        = w_strobe & (r_addr == ADDR_STREAM) & ~w_empty;
    assign w_rd_ptr_nxt = r_rd_ptr + AW'(w_pop);
    assign w_left       = r_count - CW'(w_pop);
    assign w_count_nxt  = w_left + CW'(w_push);
    assign w_ovf_nxt    = (fifo_data_in_valid & w_full)
                        | (r_ovf & ~(w_strobe & (r_addr == ADDR_STATUS)));
    // A byte pushed into an empty FIFO is the next head before it is readable from the array.
    assign w_head_nxt   = (w_left != '0) ? r_mem[w_rd_ptr_nxt] : (w_push ? fifo_data_in : 8'h00);
    assign w_status_nxt = {w_ovf_nxt, 7'(w_count_nxt)};
    assign fifo_full_out = w_full;

    always_ff @(posedge system_clock) begin
        if (w_push) r_mem[r_wr_ptr] <= fifo_data_in;
    end

    always_ff @(posedge system_clock) begin
        if (system_reset) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
            r_ovf    <= 1'b0;
        end else begin
            r_rd_ptr <= w_rd_ptr_nxt;
            r_wr_ptr <= r_wr_ptr + AW'(w_push);
            r_count  <= w_count_nxt;
            r_ovf    <= w_ovf_nxt;
        end
    end
`else
    logic w_unused_fifo;
    assign w_unused_fifo = &{1'b0, fifo_data_in, fifo_data_in_valid, FIFO_DEPTH};
    assign fifo_full_out = 1'b0;
`endif

    // Read mux looks at post-update values so the response reflects the strobe just taken.
    always_comb begin
        w_rd_dat = 8'h00;
        w_rd_vld = 1'b0;
        case (w_cur_addr)
            ADDR_CHIP_ID: begin w_rd_dat = CHIP_ID;       w_rd_vld = 1'b1; end
            ADDR_SCRATCH: begin w_rd_dat = w_scratch_nxt; w_rd_vld = 1'b1; end
            ADDR_CONTROL: begin w_rd_dat = w_control_nxt; w_rd_vld = 1'b1; end
`ifdef SPI_REGISTER_FILE_FIFO_EN
            ADDR_STREAM:  begin w_rd_dat = w_head_nxt;    w_rd_vld = 1'b1; end
            ADDR_STATUS:  begin w_rd_dat = w_status_nxt;  w_rd_vld = 1'b1; end
`endif
            default: ;
        endcase
    end

    always_ff @(posedge system_clock) begin
        // Edge history tracks the pins even in reset, so a chip-select held across reset cannot re-trigger.
        r_addr_vld_d <= subperipheral_address_in_valid;
        r_data_vld_d <= subperipheral_data_in_valid;
        if (system_reset) begin
            r_state        <= ST_IDLE;
            r_addr         <= 8'h00;
            r_scratch      <= 8'h00;
            r_control      <= 8'h00;
            r_data_out     <= 8'h00;
            r_data_out_vld <= 1'b0;
        end else begin
            r_scratch <= w_scratch_nxt;
            r_control <= w_control_nxt;
            case (r_state)
                ST_IDLE: begin
                    if (w_addr_rise) begin
                        r_state        <= ST_ADDRESSED;
                        r_addr         <= subperipheral_address_in;
                        r_data_out     <= w_rd_dat;
                        r_data_out_vld <= w_rd_vld;
                    end else begin
                        r_data_out     <= 8'h00;
                        r_data_out_vld <= 1'b0;
                    end
                end
                ST_ADDRESSED: begin
                    if (!subperipheral_address_in_valid) begin
                        r_state        <= ST_IDLE;
                        r_data_out     <= 8'h00;
                        r_data_out_vld <= 1'b0;
                    end else begin
                        r_data_out     <= w_rd_dat;
                        r_data_out_vld <= w_rd_vld;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign subperipheral_data_out       = r_data_out;
    assign subperipheral_data_out_valid = r_data_out_vld;
    assign control_out                  = r_control;
endmodule

// File: tb/tb_spi_register_file.sv
// Bench for spi_register_file; FIFO scenarios build when SPI_REGISTER_FILE_FIFO_EN is defined.
module tb_spi_register_file;
    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] addr;
    logic       addr_vld;
    logic [7:0] din;
    logic       din_vld;
    logic [7:0] dout;
    logic       dout_vld;
    logic [7:0] ctrl;
    logic [7:0] fdin;
    logic       fdin_vld;
    logic       full;

    int n_cmp  = 0;
    int n_fail = 0;
    logic [8:0] exp_q[$];
    logic [8:0] got;
    logic [8:0] exp;

    spi_register_file #(.CHIP_ID(8'h81), .FIFO_DEPTH(16)) dut (
        .system_clock                   (clk),
        .system_reset                   (rst),
        .subperipheral_address_in       (addr),
        .subperipheral_address_in_valid (addr_vld),
        .subperipheral_data_in          (din),
        .subperipheral_data_in_valid    (din_vld),
        .subperipheral_data_out         (dout),
        .subperipheral_data_out_valid   (dout_vld),
        .control_out                    (ctrl),
        .fifo_data_in                   (fdin),
        .fifo_data_in_valid             (fdin_vld),
        .fifo_full_out                  (full)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start(input logic [7:0] a);
        addr = a; addr_vld = 1'b1; tick();
    endtask

    task automatic strobe(input logic [7:0] d);
        din = d; din_vld = 1'b1; tick();
        din_vld = 1'b0; tick();
    endtask

    task automatic stop();
        addr_vld = 1'b0; tick();
    endtask

    task automatic test_reset();
        rst = 1'b1; addr = 8'h00; addr_vld = 1'b0; din = 8'h00; din_vld = 1'b0;
        fdin = 8'h00; fdin_vld = 1'b0;
        tick(); tick();
        rst = 1'b0; tick();
        exp_q.push_back(9'h000);
        got = {dout_vld, dout}; exp = exp_q.pop_front(); n_cmp++;
        if (got !== exp) begin n_fail++; $display("FAIL reset_dout: got %h want %h", got, exp); end
        n_cmp++;
        if (ctrl !== 8'h00) begin n_fail++; $display("FAIL reset_control: got %h want 00", ctrl); end
        n_cmp++;
        if (full !== 1'b0) begin n_fail++; $display("FAIL reset_full: got %b want 0", full); end
    endtask

    task automatic test_chip_id();
        exp_q.push_back({1'b1, 8'h81});
        start(8'hDB);
        got = {dout_vld, dout}; exp = exp_q.pop_front(); n_cmp++;
        if (got !== exp) begin n_fail++; $display("FAIL chip_id_read: got %h want %h", got, exp); end
        exp_q.push_back({1'b1, 8'h81});
        strobe(8'h00);
        got = {dout_vld, dout}; exp = exp_q.pop_front(); n_cmp++;
        if (got !== exp) begin n_fail++; $display("FAIL chip_id_readonly: got %h want %h", got, exp); end
        exp_q.push_back(9'h000);
        stop();
        got = {dout_vld, dout}; exp = exp_q.pop_front(); n_cmp++;
        if (got !== exp) begin n_fail++; $display("FAIL chip_id_release: got %h want %h", got, exp); end
    endtask

    task automatic test_control_write();
        exp_q.push_back({1'b1, 8'h00});
        start(8'h11);
        got = {dout_vld, dout}; exp = exp_q.pop_front(); n_cmp++;
        if (got !== exp) begin n_fail++; $display("FAIL ctrl_initial: got %h want %h", got, exp); end
        strobe(8'h5A);
        n_cmp++;
        if (ctrl !== 8'h5A) begin n_fail++; $display("FAIL ctrl_byte1: got %h want 5a", ctrl); end
        strobe(8'hC3);
        n_cmp++;
        if (ctrl !== 8'hC3) begin n_fail++; $display("FAIL ctrl_byte2: got %h want c3", ctrl); end
        stop();
        exp_q.push_back({1'b1, 8'hC3});
        start(8'h11);
        got = {dout_vld, dout}; exp = exp_q.pop_front(); n_cmp++;
        if (got !== exp) begin n_fail++; $display("FAIL ctrl_readback: got %h want %h", got, exp); end
        stop();
    endtask

    task automatic test_scratch();
        exp_q.push_back({1'b1, 8'h00});
        start(8'h10);
        got = {dout_vld, dout}; exp = exp_q.pop_front(); n_cmp++;
        if (got !== exp) begin n_fail++; $display("FAIL scratch_initial: got %h want %h", got, exp); end
        exp_q.push_back({1'b1, 8'h3C});
        strobe(8'h3C);
        got = {dout_vld, dout}; exp = exp_q.pop_front(); n_cmp++;
        if (got !== exp) begin n_fail++; $display("FAIL scratch_resample: got %h want %h", got, exp); end
        stop();
        n_cmp++;
        if (ctrl !== 8'hC3) begin n_fail++; $display("FAIL scratch_ctrl_untouched: got %h want c3", ctrl); end
    endtask

    task automatic test_level_hold();
        exp_q.push_back({1'b1, 8'h11});
        start(8'h10);
        din = 8'h11; din_vld = 1'b1; tick();
        din = 8'h22; tick(); tick();
        din_vld = 1'b0; tick();
        got = {dout_vld, dout}; exp = exp_q.pop_front(); n_cmp++;
        if (got !== exp) begin n_fail++; $display("FAIL level_hold: got %h want %h", got, exp); end
        stop();
    endtask

    task automatic test_unmapped();
        exp_q.push_back(9'h000);
        start(8'h42);
        got = {dout_vld, dout}; exp = exp_q.pop_front(); n_cmp++;
        if (got !== exp) begin n_fail++; $display("FAIL unmapped_read: got %h want %h", got, exp); end
        exp_q.push_back(9'h000);
        strobe(8'h77);
        got = {dout_vld, dout}; exp = exp_q.pop_front(); n_cmp++;
        if (got !== exp) begin n_fail++; $display("FAIL unmapped_write: got %h want %h", got, exp); end
        stop();
        exp_q.push_back({1'b1, 8'h11});
        start(8'h10);
        got = {dout_vld, dout}; exp = exp_q.pop_front(); n_cmp++;
        if (got !== exp) begin n_fail++; $display("FAIL unmapped_scratch_kept: got %h want %h", got, exp); end
        stop();
        n_cmp++;
        if (ctrl !== 8'hC3) begin n_fail++; $display("FAIL unmapped_ctrl_kept: got %h want c3", ctrl); end
    endtask

    task automatic test_reset_mid_burst();
        start(8'h11);
        strobe(8'h66);
        n_cmp++;
        if (ctrl !== 8'h66) begin n_fail++; $display("FAIL midrst_pre_ctrl: got %h want 66", ctrl); end
        fdin = 8'hE0; fdin_vld = 1'b1; tick(); tick(); fdin_vld = 1'b0;
        rst = 1'b1; tick();
        exp_q.push_back(9'h000);
        got = {dout_vld, dout}; exp = exp_q.pop_front(); n_cmp++;
        if (got !== exp) begin n_fail++; $display("FAIL midrst_dout: got %h want %h", got, exp); end
        n_cmp++;
        if (ctrl !== 8'h00) begin n_fail++; $display("FAIL midrst_ctrl: got %h want 00", ctrl); end
        rst = 1'b0; tick();
        stop();
`ifdef SPI_REGISTER_FILE_FIFO_EN
        exp_q.push_back({1'b1, 8'h00});
`else
        exp_q.push_back(9'h000);
`endif
        start(8'h21);
        got = {dout_vld, dout}; exp = exp_q.pop_front(); n_cmp++;
        if (got !== exp) begin n_fail++; $display("FAIL midrst_status: got %h want %h", got, exp); end
        stop();
    endtask

`ifdef SPI_REGISTER_FILE_FIFO_EN
    task automatic test_fifo_fill();
        for (int i = 1; i <= 16; i++) begin
            fdin = 8'(i); fdin_vld = 1'b1; tick();
        end
        fdin_vld = 1'b0;
        n_cmp++;
        if (full !== 1'b1) begin n_fail++; $display("FAIL fill_full: got %b want 1", full); end
        fdin = 8'hFF; fdin_vld = 1'b1; tick(); fdin_vld = 1'b0;
        n_cmp++;
        if (full !== 1'b1) begin n_fail++; $display("FAIL fill_full_after_drop: got %b want 1", full); end
        exp_q.push_back({1'b1, 8'h90});
        start(8'h21);
        got = {dout_vld, dout}; exp = exp_q.pop_front(); n_cmp++;
        if (got !== exp) begin n_fail++; $display("FAIL status_overflow: got %h want %h", got, exp); end
        strobe(8'h00);
        stop();
        exp_q.push_back({1'b1, 8'h10});
        start(8'h21);
        got = {dout_vld, dout}; exp = exp_q.pop_front(); n_cmp++;
        if (got !== exp) begin n_fail++; $display("FAIL status_cleared: got %h want %h", got, exp); end
        stop();
    endtask

    task automatic test_fifo_drain();
        exp_q.push_back({1'b1, 8'h01});
        start(8'h20);
        got = {dout_vld, dout}; exp = exp_q.pop_front(); n_cmp++;
        if (got !== exp) begin n_fail++; $display("FAIL drain_head: got %h want %h", got, exp); end
        for (int k = 1; k <= 17; k++) begin
            exp_q.push_back({1'b1, (k < 16) ? 8'(k + 1) : 8'h00});
            strobe(8'h00);
            got = {dout_vld, dout}; exp = exp_q.pop_front(); n_cmp++;
            if (got !== exp) begin n_fail++; $display("FAIL drain_byte%0d: got %h want %h", k, got, exp); end
        end
        stop();
        exp_q.push_back({1'b1, 8'h00});
        start(8'h21);
        got = {dout_vld, dout}; exp = exp_q.pop_front(); n_cmp++;
        if (got !== exp) begin n_fail++; $display("FAIL drain_count: got %h want %h", got, exp); end
        stop();
    endtask

    task automatic test_push_pop_same_cycle();
        for (int i = 0; i < 5; i++) begin
            fdin = 8'hA0 + 8'(i); fdin_vld = 1'b1; tick();
        end
        fdin_vld = 1'b0;
        exp_q.push_back({1'b1, 8'hA0});
        start(8'h20);
        got = {dout_vld, dout}; exp = exp_q.pop_front(); n_cmp++;
        if (got !== exp) begin n_fail++; $display("FAIL pushpop_head: got %h want %h", got, exp); end
        exp_q.push_back({1'b1, 8'hA1});
        din_vld = 1'b1; fdin = 8'hA5; fdin_vld = 1'b1; tick();
        din_vld = 1'b0; fdin_vld = 1'b0;
        got = {dout_vld, dout}; exp = exp_q.pop_front(); n_cmp++;
        if (got !== exp) begin n_fail++; $display("FAIL pushpop_next: got %h want %h", got, exp); end
        tick();
        stop();
        exp_q.push_back({1'b1, 8'h05});
        start(8'h21);
        got = {dout_vld, dout}; exp = exp_q.pop_front(); n_cmp++;
        if (got !== exp) begin n_fail++; $display("FAIL pushpop_count: got %h want %h", got, exp); end
        stop();
    endtask

    task automatic test_push_into_empty();
        exp_q.push_back({1'b1, 8'h00});
        start(8'h20);
        got = {dout_vld, dout}; exp = exp_q.pop_front(); n_cmp++;
        if (got !== exp) begin n_fail++; $display("FAIL empty_read: got %h want %h", got, exp); end
        exp_q.push_back({1'b1, 8'h5E});
        fdin = 8'h5E; fdin_vld = 1'b1; tick(); fdin_vld = 1'b0;
        got = {dout_vld, dout}; exp = exp_q.pop_front(); n_cmp++;
        if (got !== exp) begin n_fail++; $display("FAIL empty_push_visible: got %h want %h", got, exp); end
        exp_q.push_back({1'b1, 8'h00});
        strobe(8'h00);
        got = {dout_vld, dout}; exp = exp_q.pop_front(); n_cmp++;
        if (got !== exp) begin n_fail++; $display("FAIL empty_after_pop: got %h want %h", got, exp); end
        stop();
    endtask
`else
    task automatic test_fifo_disabled();
        for (int i = 0; i < 20; i++) begin
            fdin = 8'(i); fdin_vld = 1'b1; tick();
        end
        fdin_vld = 1'b0;
        n_cmp++;
        if (full !== 1'b0) begin n_fail++; $display("FAIL nofifo_full: got %b want 0", full); end
        exp_q.push_back(9'h000);
        start(8'h20);
        got = {dout_vld, dout}; exp = exp_q.pop_front(); n_cmp++;
        if (got !== exp) begin n_fail++; $display("FAIL nofifo_stream: got %h want %h", got, exp); end
        exp_q.push_back(9'h000);
        strobe(8'h00);
        got = {dout_vld, dout}; exp = exp_q.pop_front(); n_cmp++;
        if (got !== exp) begin n_fail++; $display("FAIL nofifo_stream_strobe: got %h want %h", got, exp); end
        stop();
        exp_q.push_back(9'h000);
        start(8'h21);
        got = {dout_vld, dout}; exp = exp_q.pop_front(); n_cmp++;
        if (got !== exp) begin n_fail++; $display("FAIL nofifo_status: got %h want %h", got, exp); end
        stop();
    endtask
`endif

    initial begin
        test_reset();
        test_chip_id();
        test_control_write();
        test_scratch();
        test_level_hold();
        test_unmapped();
`ifdef SPI_REGISTER_FILE_FIFO_EN
        test_fifo_fill();
        test_fifo_drain();
        test_push_pop_same_cycle();
        test_reset_mid_burst();
        test_push_into_empty();
`else
        test_fifo_disabled();
        test_reset_mid_burst();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
